// File: rtl/reg_scoreboard_if.sv
// Issue/completion/status bundle between the ID stage and the long-latency register scoreboard.
// The ID stage drives through the master modport. The scoreboard uses the slave modport.
interface reg_scoreboard_if #(
  parameter int MAX_OUTSTANDING = 4
) ();
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          i_issue_valid;
  logic [4:0]    i_issue_rs1;
  logic [4:0]    i_issue_rs2;
  logic [4:0]    i_issue_rd;
  logic          i_issue_long;
  logic          o_issue_ready;
  logic          o_stall;
  logic [1:0]    o_stall_cause;
  logic          i_cmpl_valid;
  logic [4:0]    i_cmpl_rd;
  logic [31:0]   o_pending;
  logic [CW-1:0] o_outstanding;
  logic          o_err_spurious;
  logic          o_timeout;
  logic [31:0]   o_stall_cycles;

  modport master (
    output i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_rd, i_issue_long,
    output i_cmpl_valid, i_cmpl_rd,
    input  o_issue_ready, o_stall, o_stall_cause, o_pending, o_outstanding,
    input  o_err_spurious, o_timeout, o_stall_cycles
  );

  modport slave (
    input  i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_rd, i_issue_long,
    input  i_cmpl_valid, i_cmpl_rd,
    output o_issue_ready, o_stall, o_stall_cause, o_pending, o_outstanding,
    output o_err_spurious, o_timeout, o_stall_cycles
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Scoreboard for destination registers of in-flight long-latency ops.
// It stalls ID on RAW, WAW or capacity hazards until the producing unit signals writeback.
module reg_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CMPL_BYPASS     = 1,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic             i_clk,
  input logic             i_rst_n,
  reg_scoreboard_if.slave sb
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);
  localparam bit            WD_ON   = (TIMEOUT_CYCLES != 0);
  localparam bit            BYPASS  = (CMPL_BYPASS != 0);

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_WAW  = 2'd2,
    CAUSE_FULL = 2'd3
  } cause_e;

  logic [31:0]   pending, pending_nxt, eff_pend;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [WW-1:0] wd, wd_nxt;
  logic          timeout;
  logic          err_spurious;
  logic [31:0]   stall_cycles;
  logic          cmpl_hit, long_rd, raw, waw, full, accept_long, stall;
  cause_e        cause;

  // Bit 0 is never set, so a completion to x0 always counts as spurious.
  assign cmpl_hit = sb.i_cmpl_valid && pending[sb.i_cmpl_rd];
  assign long_rd  = sb.i_issue_long && (sb.i_issue_rd != 5'd0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    eff_pend = pending;
    if (BYPASS && sb.i_cmpl_valid) eff_pend[sb.i_cmpl_rd] = 1'b0;
  end

  assign raw  = eff_pend[sb.i_issue_rs1] | eff_pend[sb.i_issue_rs2];
  assign waw  = long_rd && eff_pend[sb.i_issue_rd];
  assign full = long_rd && (outstanding == MAX_CNT) && !(BYPASS && cmpl_hit);

  always_comb begin
    cause = CAUSE_NONE;
    if (sb.i_issue_valid) begin
      if (raw)       cause = CAUSE_RAW;
      else if (waw)  cause = CAUSE_WAW;
      else if (full) cause = CAUSE_FULL;
    end
  end

  assign stall       = (cause != CAUSE_NONE);
  assign accept_long = sb.i_issue_valid && !stall && long_rd;

  assign sb.o_issue_ready  = !stall;
  assign sb.o_stall        = stall;
  assign sb.o_stall_cause  = cause;
  assign sb.o_pending      = pending;
  assign sb.o_outstanding  = outstanding;
  assign sb.o_err_spurious = err_spurious;
  assign sb.o_timeout      = timeout;
  assign sb.o_stall_cycles = stall_cycles;

  // Clear before set, so completion and re-issue of the same rd leave the bit pending.
  always_comb begin
    pending_nxt = pending;
    if (cmpl_hit)    pending_nxt[sb.i_cmpl_rd]  = 1'b0;
    if (accept_long) pending_nxt[sb.i_issue_rd] = 1'b1;

    outstanding_nxt = outstanding;
    case ({accept_long, cmpl_hit})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase

    wd_nxt = '0;
    if (!cmpl_hit && (outstanding != '0)) wd_nxt = (wd == WD_MAX) ? wd : wd + WW'(1);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending      <= '0;
      outstanding  <= '0;
      wd           <= '0;
      timeout      <= 1'b0;
      err_spurious <= 1'b0;
      stall_cycles <= '0;
    end else begin
      pending      <= pending_nxt;
      outstanding  <= outstanding_nxt;
      wd           <= wd_nxt;
      timeout      <= timeout | (WD_ON && (wd_nxt == WD_MAX));
      err_spurious <= sb.i_cmpl_valid && !pending[sb.i_cmpl_rd];
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard.
// It has a vector table with a scoreboard queue for registered state, plus hand sequences for reset, watchdog and no-bypass.
module tb_reg_scoreboard;
  logic clk;
  logic rst_n;

  reg_scoreboard_if #(.MAX_OUTSTANDING(4)) sb ();
  reg_scoreboard_if #(.MAX_OUTSTANDING(4)) sb_nb ();

  reg_scoreboard #(.MAX_OUTSTANDING(4), .CMPL_BYPASS(1), .TIMEOUT_CYCLES(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .sb(sb)
  );
  reg_scoreboard #(.MAX_OUTSTANDING(4), .CMPL_BYPASS(0), .TIMEOUT_CYCLES(16)) u_dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .sb(sb_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int valid, rs1, rs2, rd, is_long, cv, crd;
    int ready, cause;
    int pend, outs, err;
  } vec_t;

  typedef struct {
    string name;
    int pend, outs, err;
  } exp_t;

  vec_t vecs[26];
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic drive(input vec_t v);
    sb.i_issue_valid = v.valid[0];
    sb.i_issue_rs1   = 5'(v.rs1);
    sb.i_issue_rs2   = 5'(v.rs2);
    sb.i_issue_rd    = 5'(v.rd);
    sb.i_issue_long  = v.is_long[0];
    sb.i_cmpl_valid  = v.cv[0];
    sb.i_cmpl_rd     = 5'(v.crd);
  endtask

  // Called at posedge+1. Combinational outputs are checked at the negedge.
  // Registered state is checked after the next edge.
  task automatic step(input vec_t v);
    exp_t e, got;
    drive(v);
    @(negedge clk);
    check({v.name, "/ready"}, 32'(sb.o_issue_ready), 32'(v.ready));
    check({v.name, "/cause"}, 32'(sb.o_stall_cause), 32'(v.cause));
    check({v.name, "/stall"}, 32'(sb.o_stall), 32'(v.valid != 0 && v.ready == 0));
    e.name = v.name; e.pend = v.pend; e.outs = v.outs; e.err = v.err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({got.name, "/pending"},  sb.o_pending,                32'(got.pend));
    check({got.name, "/outstand"}, 32'(sb.o_outstanding),       32'(got.outs));
    check({got.name, "/err_spur"}, 32'(sb.o_err_spurious),      32'(got.err));
  endtask

  function automatic vec_t idle(input string name, input int pend, input int outs, input int err);
    vec_t v = '{name, 0, 0, 0, 0, 0, 0, 0, 1, 0, pend, outs, err};
    return v;
  endfunction

  initial begin
    //          name   vld rs1 rs2 rd lng cv crd rdy cause pend  out err
    vecs[0]  = '{"lng5",  1, 0, 0, 5, 1, 0, 0, 1, 0, 'h20, 1, 0};
    vecs[1]  = '{"raw1",  1, 5, 0,10, 0, 0, 0, 0, 1, 'h20, 1, 0};
    vecs[2]  = '{"novld", 0, 5, 5, 5, 1, 0, 0, 1, 0, 'h20, 1, 0};
    vecs[3]  = '{"raw2",  1, 0, 5,10, 0, 0, 0, 0, 1, 'h20, 1, 0};
    vecs[4]  = '{"rawbyp",1, 5, 0,10, 0, 1, 5, 1, 0, 'h00, 0, 0};
    vecs[5]  = '{"lng1",  1, 0, 0, 1, 1, 0, 0, 1, 0, 'h02, 1, 0};
    vecs[6]  = '{"lng2",  1, 0, 0, 2, 1, 0, 0, 1, 0, 'h06, 2, 0};
    vecs[7]  = '{"lng3",  1, 0, 0, 3, 1, 0, 0, 1, 0, 'h0E, 3, 0};
    vecs[8]  = '{"lng4",  1, 0, 0, 4, 1, 0, 0, 1, 0, 'h1E, 4, 0};
    vecs[9]  = '{"full",  1, 0, 0, 6, 1, 0, 0, 0, 3, 'h1E, 4, 0};
    vecs[10] = '{"fullbp",1, 0, 0, 6, 1, 1, 2, 1, 0, 'h5A, 4, 0};
    vecs[11] = '{"cmpl1", 0, 0, 0, 0, 0, 1, 1, 1, 0, 'h58, 3, 0};
    vecs[12] = '{"lng7",  1, 0, 0, 7, 1, 0, 0, 1, 0, 'hD8, 4, 0};
    vecs[13] = '{"waw",   1, 0, 0, 7, 1, 0, 0, 0, 2, 'hD8, 4, 0};
    vecs[14] = '{"wawbyp",1, 0, 0, 7, 1, 1, 7, 1, 0, 'hD8, 4, 0};
    vecs[15] = '{"prio",  1, 4, 0, 3, 1, 0, 0, 0, 1, 'hD8, 4, 0};
    vecs[16] = '{"spur9", 0, 0, 0, 0, 0, 1, 9, 1, 0, 'hD8, 4, 1};
    vecs[17] = '{"spur9b",0, 0, 0, 0, 0, 0, 0, 1, 0, 'hD8, 4, 0};
    vecs[18] = '{"spur0", 0, 0, 0, 0, 0, 1, 0, 1, 0, 'hD8, 4, 1};
    vecs[19] = '{"spur0b",0, 0, 0, 0, 0, 0, 0, 1, 0, 'hD8, 4, 0};
    vecs[20] = '{"drn3",  0, 0, 0, 0, 0, 1, 3, 1, 0, 'hD0, 3, 0};
    vecs[21] = '{"drn4",  0, 0, 0, 0, 0, 1, 4, 1, 0, 'hC0, 2, 0};
    vecs[22] = '{"drn6",  0, 0, 0, 0, 0, 1, 6, 1, 0, 'h80, 1, 0};
    vecs[23] = '{"drn7",  0, 0, 0, 0, 0, 1, 7, 1, 0, 'h00, 0, 0};
    vecs[24] = '{"lngx0", 1, 0, 0, 0, 1, 0, 0, 1, 0, 'h00, 0, 0};
    vecs[25] = '{"raw0",  1, 0, 0, 0, 0, 0, 0, 1, 0, 'h00, 0, 0};

    rst_n = 1'b0;
    drive(idle("init", 0, 0, 0));
    sb_nb.i_issue_valid = 1'b0; sb_nb.i_issue_rs1 = '0; sb_nb.i_issue_rs2 = '0;
    sb_nb.i_issue_rd = '0; sb_nb.i_issue_long = 1'b0; sb_nb.i_cmpl_valid = 1'b0; sb_nb.i_cmpl_rd = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst/pending",  sb.o_pending, 32'd0);
    check("rst/outstand", 32'(sb.o_outstanding), 32'd0);
    check("rst/timeout",  32'(sb.o_timeout), 32'd0);
    check("rst/stallcnt", sb.o_stall_cycles, 32'd0);

    // Main vector table
    foreach (vecs[i]) begin
      step(vecs[i]);
      if (vecs[i].valid != 0 && vecs[i].ready == 0) exp_stalls++;
    end
    check("tbl/stallcnt", sb.o_stall_cycles, 32'(exp_stalls));
    check("tbl/timeout",  32'(sb.o_timeout), 32'd0);

    // Async reset mid-flight with three pending registers
    step('{"r10", 1, 0, 0, 10, 1, 0, 0, 1, 0, 'h400,  1, 0});
    step('{"r11", 1, 0, 0, 11, 1, 0, 0, 1, 0, 'hC00,  2, 0});
    step('{"r12", 1, 0, 0, 12, 1, 0, 0, 1, 0, 'h1C00, 3, 0});
    drive(idle("rst", 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("arst/pending",  sb.o_pending, 32'd0);
    check("arst/outstand", 32'(sb.o_outstanding), 32'd0);
    check("arst/err",      32'(sb.o_err_spurious), 32'd0);
    check("arst/stallcnt", sb.o_stall_cycles, 32'd0);
    check("arst/timeout",  32'(sb.o_timeout), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step('{"postrst", 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 1});

    // Watchdog: one op pending with no completion for 16 cycles
    step('{"wd_lng8", 1, 0, 0, 8, 1, 0, 0, 1, 0, 'h100, 1, 0});
    for (int k = 1; k <= 16; k++) begin
      step(idle($sformatf("wd%0d", k), 'h100, 1, 0));
      check($sformatf("wd%0d/timeout", k), 32'(sb.o_timeout), 32'(k >= 16));
    end
    step('{"wd_cmpl", 0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0});
    for (int k = 0; k < 3; k++) begin
      step(idle("wd_post", 0, 0, 0));
      check("wd_post/timeout", 32'(sb.o_timeout), 32'd1);
    end

    // Instance without completion bypass: the hazard clears one cycle after completion
    sb_nb.i_issue_valid = 1'b1; sb_nb.i_issue_long = 1'b1; sb_nb.i_issue_rd = 5'd5;
    @(negedge clk);
    check("nb/lng5_ready", 32'(sb_nb.o_issue_ready), 32'd1);
    @(posedge clk); #1;
    check("nb/pending", sb_nb.o_pending, 32'h20);
    sb_nb.i_issue_long = 1'b0; sb_nb.i_issue_rd = 5'd10; sb_nb.i_issue_rs1 = 5'd5;
    @(negedge clk);
    check("nb/raw_ready", 32'(sb_nb.o_issue_ready), 32'd0);
    check("nb/raw_cause", 32'(sb_nb.o_stall_cause), 32'd1);
    @(posedge clk); #1;
    sb_nb.i_cmpl_valid = 1'b1; sb_nb.i_cmpl_rd = 5'd5;
    @(negedge clk);
    check("nb/cmpl_ready", 32'(sb_nb.o_issue_ready), 32'd0);
    check("nb/cmpl_cause", 32'(sb_nb.o_stall_cause), 32'd1);
    @(posedge clk); #1;
    sb_nb.i_cmpl_valid = 1'b0;
    @(negedge clk);
    check("nb/after_ready", 32'(sb_nb.o_issue_ready), 32'd1);
    check("nb/after_pend",  sb_nb.o_pending, 32'd0);
    check("nb/stallcnt",    sb_nb.o_stall_cycles, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
